// File: rtl/cpu_pkg.sv
// Shared pipeline constants and the hazard controller's state type.
// Pure declarations: no logic, no latency, no flow control.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 16;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // BR_HOLD is the second stall cycle of a branch that waits on a load.
  typedef enum logic {
    RUN     = 1'b0,
    BR_HOLD = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_addr_match.sv
// One source-operand compare against the EX destination; register 0 never hits.
// Purely combinational; no flow control.
module hazard_addr_match
  import cpu_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic [AW-1:0] src_addr,
  input  logic          src_used,
  input  logic [AW-1:0] dst_addr,
  output logic          hit
);

  logic dst_nonzero;

  assign dst_nonzero = (dst_addr != AW'(ZERO_REG));
  assign hit         = src_used && dst_nonzero && (dst_addr == src_addr);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush/freeze controller for hazards the EX bypass network cannot cover.
// Outputs are 0-cycle combinational from state and inputs; a data-memory wait freezes everything.
module hazard_stall_unit #(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int CNT_W      = cpu_pkg::CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] IF_ID_RSaddr_i,
  input  logic [REG_ADDR_W-1:0] IF_ID_RTaddr_i,
  input  logic                  ID_uses_RT_i,
  input  logic                  ID_is_branch_i,
  input  logic                  ID_EX_MemRead_i,
  input  logic                  ID_EX_RegWrite_i,
  input  logic [REG_ADDR_W-1:0] ID_EX_RDaddr_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ready_i,
  output logic                  PC_write_o,
  output logic                  IF_ID_write_o,
  output logic                  ID_EX_bubble_o,
  output logic                  IF_ID_flush_o,
  output logic                  freeze_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  import cpu_pkg::*;

  hz_state_t        state_q;
  hz_state_t        state_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic hit_rs;
  logic hit_rt;
  logic rd_match;
  logic freeze;
  logic load_use;
  logic branch_alu;
  logic branch_load;
  logic stall;

  hazard_addr_match #(.AW(REG_ADDR_W)) u_match_rs (
    .src_addr (IF_ID_RSaddr_i),
    .src_used (1'b1),
    .dst_addr (ID_EX_RDaddr_i),
    .hit      (hit_rs)
  );

  hazard_addr_match #(.AW(REG_ADDR_W)) u_match_rt (
    .src_addr (IF_ID_RTaddr_i),
    .src_used (ID_uses_RT_i),
    .dst_addr (ID_EX_RDaddr_i),
    .hit      (hit_rt)
  );

  assign rd_match    = hit_rs || hit_rt;
  assign freeze      = dmem_req_i && !dmem_ready_i;
  assign load_use    = ID_EX_MemRead_i && rd_match;
  assign branch_alu  = ID_is_branch_i && ID_EX_RegWrite_i && !ID_EX_MemRead_i && rd_match;
  assign branch_load = ID_is_branch_i && ID_EX_MemRead_i && rd_match;

  // A branch behind a load is covered by load_use for its first cycle;
  // BR_HOLD supplies the second one while the load reaches MEM/WB.
  always_comb begin
    stall = 1'b0;
    if (!freeze) begin
      if (state_q == BR_HOLD) begin
        stall = 1'b1;
      end else begin
        stall = load_use || branch_alu;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (!freeze) begin
      if (state_q == BR_HOLD) begin
        state_d = RUN;
      end else if (branch_load) begin
        state_d = BR_HOLD;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Freeze cycles are not counted; only true pipeline bubbles are.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Reset forces the free-running defaults regardless of state or inputs.
  always_comb begin
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    ID_EX_bubble_o = 1'b0;
    IF_ID_flush_o  = 1'b0;
    freeze_o       = 1'b0;
    if (!rst_i) begin
      if (freeze) begin
        PC_write_o    = 1'b0;
        IF_ID_write_o = 1'b0;
        freeze_o      = 1'b1;
      end else if (stall) begin
        PC_write_o     = 1'b0;
        IF_ID_write_o  = 1'b0;
        ID_EX_bubble_o = 1'b1;
      end else begin
        IF_ID_flush_o = branch_taken_i;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: single-cycle vector table plus multi-cycle sequences.
module tb_hazard_stall_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rs, rt, rd;
  logic        uses_rt, is_br, memrd, regwr, taken, dreq, drdy;
  logic        pc_w, ifid_w, bubble, flush, freeze;
  logic [15:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  hazard_stall_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .IF_ID_RSaddr_i   (rs),
    .IF_ID_RTaddr_i   (rt),
    .ID_uses_RT_i     (uses_rt),
    .ID_is_branch_i   (is_br),
    .ID_EX_MemRead_i  (memrd),
    .ID_EX_RegWrite_i (regwr),
    .ID_EX_RDaddr_i   (rd),
    .branch_taken_i   (taken),
    .dmem_req_i       (dreq),
    .dmem_ready_i     (drdy),
    .PC_write_o       (pc_w),
    .IF_ID_write_o    (ifid_w),
    .ID_EX_bubble_o   (bubble),
    .IF_ID_flush_o    (flush),
    .freeze_o         (freeze),
    .stall_cnt_o      (cnt)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_br;
    logic       memrd;
    logic       regwr;
    logic [4:0] rd;
    logic       taken;
    logic       dreq;
    logic       drdy;
    logic       pc;
    logic       ifid;
    logic       bub;
    logic       fl;
    logic       fz;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic a_uses,
                       input logic a_br, input logic a_memrd, input logic a_regwr,
                       input logic [4:0] a_rd, input logic a_taken, input logic a_dreq,
                       input logic a_drdy);
    rs = a_rs; rt = a_rt; uses_rt = a_uses; is_br = a_br; memrd = a_memrd;
    regwr = a_regwr; rd = a_rd; taken = a_taken; dreq = a_dreq; drdy = a_drdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_out(input string tag, input logic e_pc, input logic e_bub,
                         input logic e_fl, input logic e_fz);
    chk({tag, ".pc_write"}, 32'(pc_w), 32'(e_pc));
    chk({tag, ".ifid_write"}, 32'(ifid_w), 32'(e_pc));
    chk({tag, ".bubble"}, 32'(bubble), 32'(e_bub));
    chk({tag, ".flush"}, 32'(flush), 32'(e_fl));
    chk({tag, ".freeze"}, 32'(freeze), 32'(e_fz));
  endtask

  logic [15:0] exp_cnt;

  initial begin
    // rs  rt  uses br memrd regwr rd  taken dreq drdy | pc ifid bub fl fz
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[1]  = '{5'd2, 5'd4, 1, 0, 1, 1, 5'd2, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{5'd5, 5'd2, 1, 0, 1, 1, 5'd2, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{5'd5, 5'd2, 0, 0, 1, 1, 5'd2, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[4]  = '{5'd0, 5'd0, 1, 0, 1, 1, 5'd0, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[5]  = '{5'd6, 5'd1, 1, 0, 0, 1, 5'd6, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[6]  = '{5'd6, 5'd1, 1, 1, 0, 1, 5'd6, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[7]  = '{5'd7, 5'd6, 0, 1, 0, 1, 5'd6, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[8]  = '{5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[9]  = '{5'd3, 5'd4, 1, 1, 0, 0, 5'd0, 1, 0, 0, 1, 1, 0, 1, 0};
    vecs[10] = '{5'd2, 5'd4, 1, 0, 1, 1, 5'd2, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[11] = '{5'd2, 5'd4, 1, 0, 1, 1, 5'd2, 0, 1, 0, 0, 0, 0, 0, 1};
    vecs[12] = '{5'd1, 5'd1, 1, 0, 0, 1, 5'd9, 0, 1, 1, 1, 1, 0, 0, 0};
    vecs[13] = '{5'd3, 5'd4, 1, 1, 0, 0, 5'd0, 1, 1, 0, 0, 0, 0, 0, 1};
    vecs[14] = '{5'd6, 5'd1, 1, 1, 0, 0, 5'd6, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[15] = '{5'd1, 5'd6, 0, 0, 0, 1, 5'd6, 0, 0, 0, 1, 1, 0, 0, 0};

    // Reset with hazard and freeze inputs active: reset defaults must win.
    rst_i = 1'b1;
    drive(5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i); #1;
    chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt", 32'(cnt), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle();

    // Single-cycle table, every vector applied from RUN.
    exp_cnt = 16'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].is_br, vecs[i].memrd,
            vecs[i].regwr, vecs[i].rd, vecs[i].taken, vecs[i].dreq, vecs[i].drdy);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].pc, vecs[i].bub, vecs[i].fl, vecs[i].fz);
      chk($sformatf("vec%0d.cnt", i), 32'(cnt), 32'(exp_cnt));
      if (vecs[i].bub) exp_cnt = exp_cnt + 16'd1;
    end

    // lw $2 ; add $3,$2,$4 -> one stall then free.
    @(negedge clk_i);
    drive(5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    #1; chk_out("lu.c1", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    drive(5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1; chk_out("lu.c2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu.cnt", 32'(cnt), 32'(exp_cnt + 16'd1));
    exp_cnt = exp_cnt + 16'd1;

    // lw $2 ; beq $2,$5 -> two stalls, taken ignored in the second, flush after.
    @(negedge clk_i);
    drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    #1; chk_out("bl.c1", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1; chk_out("bl.c2", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    #1; chk_out("bl.c3", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("bl.cnt", 32'(cnt), 32'(exp_cnt + 16'd2));
    exp_cnt = exp_cnt + 16'd2;

    // Freeze 3 cycles over a load-use, then the stall on the ready cycle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      drive(5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
      #1; chk_out($sformatf("fz.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("fz.c%0d.cnt", c), 32'(cnt), 32'(exp_cnt));
    end
    @(negedge clk_i);
    drdy = 1'b1;
    #1; chk_out("fz.ready", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    idle();
    #1; chk_out("fz.after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fz.cnt", 32'(cnt), 32'(exp_cnt + 16'd1));
    exp_cnt = exp_cnt + 16'd1;

    // Freeze while in BR_HOLD keeps the pending second stall.
    @(negedge clk_i);
    drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    #1; chk_out("bhf.c1", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      #1; chk_out($sformatf("bhf.fz%0d", c), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk_i);
    drdy = 1'b1;
    #1; chk_out("bhf.hold", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    idle();
    #1; chk_out("bhf.run", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bhf.cnt", 32'(cnt), 32'(exp_cnt + 16'd2));

    // Reset for 2 cycles in the middle of BR_HOLD.
    @(negedge clk_i);
    drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
    #1; chk_out("rbh.r1", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    #1; chk_out("rbh.r2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rbh.cnt", 32'(cnt), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle();
    #1; chk_out("rbh.run", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rbh.cnt_after", 32'(cnt), 32'd0);

    // Counter saturation: drive to FFFE, then 3 more stall cycles.
    @(negedge clk_i);
    drive(5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    repeat (65534) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("sat.fffe", 32'(cnt), 32'h0000_FFFE);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("sat.ffff", 32'(cnt), 32'h0000_FFFF);
    chk_out("sat.stall", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
